// File: rtl/voice_sched.sv
// rtl/voice_sched.sv - voice allocator and per-sample channel sweeper for the note generator
//
// Accepts note-on/note-off events over a valid/ready handshake, assigns each
// note-on to one of NUM_CHANNELS accumulator channels, and keeps a per-channel
// note number and tuning word. Each sample_tick sweeps every channel once so a
// single shared phase/LUT datapath can serve all voices.
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-low reset
//   note_valid    event present
//   note_ready    event accepted on note_valid && note_ready (combinational)
//   note_on       1 = note-on, 0 = note-off
//   note_num      note identifier
//   note_tw       tuning word for note-on
//   sample_tick   one-cycle pulse starting a channel sweep
//   acc_en        per-channel active level
//   acc_clr       one-cycle phase clear for a newly allocated channel
//   curr_note     one-hot select of the swept channel, zero outside a sweep
//   tuning_word   tuning word of the swept channel, zero outside a sweep
//   chan_valid    high on every sweep cycle
//   voice_stolen  one-cycle pulse when a note-on overwrites an active channel
//   overrun       sticky, sample_tick arrived while busy

module voice_sched #(
    parameter int NUM_CHANNELS = 16,
    parameter int NUM_BITS     = 32,
    parameter int NOTE_BITS    = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    note_valid,
    output logic                    note_ready,
    input  logic                    note_on,
    input  logic [NOTE_BITS-1:0]    note_num,
    input  logic [NUM_BITS-1:0]     note_tw,
    input  logic                    sample_tick,
    output logic [NUM_CHANNELS-1:0] acc_en,
    output logic [NUM_CHANNELS-1:0] acc_clr,
    output logic [NUM_CHANNELS-1:0] curr_note,
    output logic [NUM_BITS-1:0]     tuning_word,
    output logic                    chan_valid,
    output logic                    voice_stolen,
    output logic                    overrun
);

    localparam int CH_BITS = $clog2(NUM_CHANNELS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EVENT = 2'd1,
        SWEEP = 2'd2
    } state_t;

    state_t                 state;

    // chan holds the index of the next channel to present during a sweep
    logic [CH_BITS-1:0]     chan;
    logic [CH_BITS-1:0]     steal_ptr;

    // Per-channel voice tables
    logic [NUM_CHANNELS-1:0] active;
    logic [NOTE_BITS-1:0]    note_tab [NUM_CHANNELS];
    logic [NUM_BITS-1:0]     tune_tab [NUM_CHANNELS];

    // Captured event, consumed in EVENT
    logic                   ev_on;
    logic [NOTE_BITS-1:0]   ev_num;
    logic [NUM_BITS-1:0]    ev_tw;

    // Allocation decode
    logic [NUM_CHANNELS-1:0] match;
    logic                    hit_any;
    logic                    free_any;
    logic [CH_BITS-1:0]      hit_idx;
    logic [CH_BITS-1:0]      free_idx;
    logic [CH_BITS-1:0]      alloc_idx;
    logic                    steal;

    // Scanning from the top down leaves the lowest matching index in
    // hit_idx/free_idx, giving lowest-index priority without a separate
    // priority encoder.
    always_comb begin
        match    = '0;
        hit_any  = 1'b0;
        free_any = 1'b0;
        hit_idx  = '0;
        free_idx = '0;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            if (active[i] && (note_tab[i] == ev_num)) begin
                match[i] = 1'b1;
                hit_any  = 1'b1;
                hit_idx  = CH_BITS'(i);
            end
            if (!active[i]) begin
                free_any = 1'b1;
                free_idx = CH_BITS'(i);
            end
        end
        steal     = !hit_any && !free_any;
        alloc_idx = hit_any ? hit_idx : (free_any ? free_idx : steal_ptr);
    end

    // Ready only in IDLE, and a tick in the same cycle wins over the event.
    assign note_ready = (state == IDLE) && !sample_tick;
    assign acc_en     = active;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            chan         <= '0;
            steal_ptr    <= '0;
            active       <= '0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                note_tab[i] <= '0;
                tune_tab[i] <= '0;
            end
            ev_on        <= 1'b0;
            ev_num       <= '0;
            ev_tw        <= '0;
            acc_clr      <= '0;
            curr_note    <= '0;
            tuning_word  <= '0;
            chan_valid   <= 1'b0;
            voice_stolen <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            acc_clr      <= '0;
            voice_stolen <= 1'b0;

            // A tick outside IDLE cannot start a sweep; it is dropped and flagged.
            if (sample_tick && (state != IDLE)) begin
                overrun <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (sample_tick) begin
                        state       <= SWEEP;
                        curr_note   <= NUM_CHANNELS'(1);
                        tuning_word <= tune_tab[0];
                        chan_valid  <= 1'b1;
                        chan        <= CH_BITS'(1);
                    end else if (note_valid) begin
                        ev_on  <= note_on;
                        ev_num <= note_num;
                        ev_tw  <= note_tw;
                        state  <= EVENT;
                    end
                end

                EVENT: begin
                    state <= IDLE;
                    if (ev_on) begin
                        active[alloc_idx]   <= 1'b1;
                        note_tab[alloc_idx] <= ev_num;
                        tune_tab[alloc_idx] <= ev_tw;
                        acc_clr             <= NUM_CHANNELS'(1) << alloc_idx;
                        if (steal) begin
                            steal_ptr    <= steal_ptr + 1'b1;
                            voice_stolen <= 1'b1;
                        end
                    end else begin
                        active <= active & ~match;
                    end
                end

                SWEEP: begin
                    // chan wraps to zero once the last channel has been presented
                    if (chan == '0) begin
                        state       <= IDLE;
                        curr_note   <= '0;
                        tuning_word <= '0;
                        chan_valid  <= 1'b0;
                    end else begin
                        curr_note   <= NUM_CHANNELS'(1) << chan;
                        tuning_word <= tune_tab[chan];
                        chan        <= chan + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_voice_sched.sv
// tb/tb_voice_sched.sv - scoreboard testbench for voice_sched

module tb_voice_sched;

    logic        clk;
    logic        rst;
    logic        note_valid;
    logic        note_ready;
    logic        note_on;
    logic [6:0]  note_num;
    logic [31:0] note_tw;
    logic        sample_tick;
    logic [15:0] acc_en;
    logic [15:0] acc_clr;
    logic [15:0] curr_note;
    logic [31:0] tuning_word;
    logic        chan_valid;
    logic        voice_stolen;
    logic        overrun;

    voice_sched #(
        .NUM_CHANNELS (16),
        .NUM_BITS     (32),
        .NOTE_BITS    (7)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .note_valid   (note_valid),
        .note_ready   (note_ready),
        .note_on      (note_on),
        .note_num     (note_num),
        .note_tw      (note_tw),
        .sample_tick  (sample_tick),
        .acc_en       (acc_en),
        .acc_clr      (acc_clr),
        .curr_note    (curr_note),
        .tuning_word  (tuning_word),
        .chan_valid   (chan_valid),
        .voice_stolen (voice_stolen),
        .overrun      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] cn;
        logic [31:0] tw;
    } sweep_t;

    typedef struct packed {
        logic [15:0] clr;
        logic        stolen;
        logic [15:0] en;
    } ev_t;

    sweep_t      sweep_q[$];
    ev_t         ev_q[$];
    sweep_t      cur_s;
    ev_t         cur_e;
    logic [31:0] exp_tw [16];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic push_sweep(input int n);
        sweep_t s;
        logic [15:0] one;
        one = 16'h0001;
        for (int i = 0; i < n; i++) begin
            s.cn = one << i;
            s.tw = exp_tw[i];
            sweep_q.push_back(s);
        end
    endtask

    task automatic push_ev(input logic [15:0] clr, input logic stolen, input logic [15:0] en);
        ev_t e;
        e.clr    = clr;
        e.stolen = stolen;
        e.en     = en;
        ev_q.push_back(e);
    endtask

    task automatic clear_tw();
        for (int i = 0; i < 16; i++) exp_tw[i] = 32'h0;
    endtask

    task automatic send_event(input logic on, input logic [6:0] num, input logic [31:0] tw);
        int n;
        n = 0;
        @(negedge clk);
        note_valid = 1'b1;
        note_on    = on;
        note_num   = num;
        note_tw    = tw;
        while (!note_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual note_ready 0 required 1 within 200 cycles");
        end
        @(posedge clk);
        #1 note_valid = 1'b0;
    endtask

    task automatic do_tick();
        push_sweep(16);
        @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        chk("sweep_ready_low", note_ready, 0);
        repeat (16) @(negedge clk);
        chk("sweep_end_valid", chan_valid, 0);
        chk("sweep_end_curr_note", curr_note, 0);
        chk("sweep_end_ready", note_ready, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Monitor: pops an expected entry whenever the DUT presents a sweep slot
    // or an allocation pulse.
    always @(negedge clk) begin
        if (rst) begin
            if (chan_valid) begin
                if (sweep_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sweep_unexpected actual curr_note %0h tw %0h required no sweep", curr_note, tuning_word);
                end else begin
                    cur_s = sweep_q.pop_front();
                    chk("sweep_curr_note", curr_note, cur_s.cn);
                    chk("sweep_tuning_word", tuning_word, cur_s.tw);
                end
            end
            if (acc_clr != 16'h0 || voice_stolen) begin
                if (ev_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pulse_unexpected actual acc_clr %0h stolen %0b required no pulse", acc_clr, voice_stolen);
                end else begin
                    cur_e = ev_q.pop_front();
                    chk("ev_acc_clr", acc_clr, cur_e.clr);
                    chk("ev_voice_stolen", voice_stolen, cur_e.stolen);
                    chk("ev_acc_en", acc_en, cur_e.en);
                end
            end
        end
    end

    initial begin
        #300000;
        errors++;
        $display("FAIL watchdog actual timeout required finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [15:0] one;
        logic [15:0] en;
        one = 16'h0001;
        rst = 1'b0;
        note_valid = 1'b0;
        note_on = 1'b0;
        note_num = '0;
        note_tw = '0;
        sample_tick = 1'b0;
        clear_tw();

        // Reset behaviour
        repeat (2) @(negedge clk);
        sample_tick = 1'b1;
        #1 chk("reset_ready_tick", note_ready, 0);
        sample_tick = 1'b0;
        #1 chk("reset_ready", note_ready, 1);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_acc_en", acc_en, 0);
        chk("rst_acc_clr", acc_clr, 0);
        chk("rst_curr_note", curr_note, 0);
        chk("rst_tuning_word", tuning_word, 0);
        chk("rst_chan_valid", chan_valid, 0);
        chk("rst_voice_stolen", voice_stolen, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_note_ready", note_ready, 1);

        // Single note-on, pulse timing, then sweep
        push_ev(16'h0001, 1'b0, 16'h0001);
        send_event(1'b1, 7'd60, 32'h0100_0000);
        @(negedge clk);
        chk("ev_t1_acc_clr", acc_clr, 0);
        chk("ev_t1_ready", note_ready, 0);
        @(negedge clk);
        chk("ev_t2_acc_clr", acc_clr, 16'h0001);
        chk("ev_t2_acc_en", acc_en, 16'h0001);
        @(negedge clk);
        chk("ev_t3_acc_clr", acc_clr, 0);
        clear_tw();
        exp_tw[0] = 32'h0100_0000;
        do_tick();

        // Fill all channels, then steal channel 0 and channel 1
        do_reset();
        en = 16'h0;
        for (int i = 0; i < 16; i++) begin
            en = en | (one << i);
            push_ev(one << i, 1'b0, en);
            send_event(1'b1, 7'(i), 32'(i + 1));
            exp_tw[i] = 32'(i + 1);
        end
        push_ev(16'h0001, 1'b1, 16'hFFFF);
        send_event(1'b1, 7'd99, 32'h5);
        push_ev(16'h0002, 1'b1, 16'hFFFF);
        send_event(1'b1, 7'd100, 32'h6);
        repeat (2) @(negedge clk);
        exp_tw[0] = 32'h5;
        exp_tw[1] = 32'h6;
        do_tick();

        // Retrigger, note-off, absent note-off
        do_reset();
        clear_tw();
        push_ev(16'h0001, 1'b0, 16'h0001);
        send_event(1'b1, 7'd60, 32'hA);
        push_ev(16'h0001, 1'b0, 16'h0001);
        send_event(1'b1, 7'd60, 32'hB);
        repeat (2) @(negedge clk);
        exp_tw[0] = 32'hB;
        do_tick();
        send_event(1'b0, 7'd60, 32'h0);
        repeat (2) @(negedge clk);
        chk("noteoff_acc_en", acc_en, 16'h0000);
        push_ev(16'h0001, 1'b0, 16'h0001);
        send_event(1'b1, 7'd62, 32'hC);
        send_event(1'b0, 7'd61, 32'h0);
        repeat (2) @(negedge clk);
        chk("noteoff_absent_acc_en", acc_en, 16'h0001);
        exp_tw[0] = 32'hC;
        do_tick();

        // Tick and event together: sweep first, event after
        push_sweep(16);
        push_ev(16'h0002, 1'b0, 16'h0003);
        @(negedge clk);
        sample_tick = 1'b1;
        note_valid = 1'b1;
        note_on = 1'b1;
        note_num = 7'd70;
        note_tw = 32'h77;
        #1 chk("collide_ready", note_ready, 0);
        @(negedge clk);
        sample_tick = 1'b0;
        chk("collide_acc_en_hold", acc_en, 16'h0001);
        n = 0;
        while (!note_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("collide_wait_cycles", n, 16);
        @(posedge clk);
        #1 note_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("collide_acc_en", acc_en, 16'h0003);
        exp_tw[1] = 32'h77;

        // Tick mid-sweep is dropped and sets sticky overrun
        push_sweep(16);
        @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        repeat (4) @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        chk("overrun_set", overrun, 1);
        repeat (11) @(negedge clk);
        chk("overrun_sweep_end", chan_valid, 0);
        chk("overrun_sweep_ready", note_ready, 1);
        repeat (3) @(negedge clk);
        chk("overrun_sticky", overrun, 1);

        // Reset mid-sweep aborts immediately
        push_sweep(3);
        @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        #1;
        chk("abort_curr_note", curr_note, 0);
        chk("abort_chan_valid", chan_valid, 0);
        chk("abort_tuning_word", tuning_word, 0);
        chk("abort_overrun", overrun, 0);
        chk("abort_acc_en", acc_en, 0);
        chk("abort_ready", note_ready, 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_no_sweep", chan_valid, 0);

        chk("sweep_q_empty", sweep_q.size(), 0);
        chk("ev_q_empty", ev_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/voice_sched.md
# voice_sched

Voice scheduler and sequencer for the multi-channel note generator. Accepts note-on/note-off events over a valid/ready handshake, allocates each note to one of NUM_CHANNELS accumulator channels, and holds a per-channel tuning-word table. On every sample tick it sweeps all channels once, presenting one-hot channel select plus that channel's tuning word, so a single shared phase/LUT datapath serves every voice. Sits between the event front end and the note generator's acc_en/acc_clr/curr_note/tuning_word inputs.

## Interface
- NUM_CHANNELS, 16, number of voices; power of two, at least 2
- NUM_BITS, 32, tuning word / phase width
- NOTE_BITS, 7, note number width
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-low reset
- note_valid  input  1  event present
- note_ready  output  1  event accepted when note_valid && note_ready at a rising edge
- note_on  input  1  1 = note-on, 0 = note-off
- note_num  input  NOTE_BITS  note identifier
- note_tw  input  NUM_BITS  tuning word for note-on; ignored for note-off
- sample_tick  input  1  one-cycle pulse that starts a channel sweep
- acc_en  output  NUM_CHANNELS  level; bit i = channel i active
- acc_clr  output  NUM_CHANNELS  one-cycle pulse clearing the phase of a newly allocated channel
- curr_note  output  NUM_CHANNELS  one-hot select of the channel being swept; zero outside a sweep
- tuning_word  output  NUM_BITS  tuning word of the selected channel; zero outside a sweep
- chan_valid  output  1  high on every sweep cycle
- voice_stolen  output  1  one-cycle pulse when a note-on overwrites an active channel
- overrun  output  1  sticky; sample_tick arrived while not IDLE

## Operation
- Per-channel state: active bit, note register (NOTE_BITS), tuning register (NUM_BITS). steal_ptr is log2(NUM_CHANNELS) bits.
- States: IDLE, EVENT, SWEEP.
- IDLE: note_ready = !sample_tick. If sample_tick is high, go to SWEEP with chan = 0; sample_tick takes priority over note_valid in the same cycle. Otherwise, on a handshake, capture note_on/note_num/note_tw and go to EVENT.
- EVENT, note-on, first rule that matches wins:
  - Retrigger: an active channel holds the same note_num. Use the lowest such index.
  - Free channel: the lowest-index inactive channel.
  - Steal: use channel steal_ptr, then steal_ptr increments modulo NUM_CHANNELS, and voice_stolen pulses.
  - Selected channel: active = 1, note and tuning registers loaded, matching acc_clr bit pulses.
- EVENT, note-off: clear the active bit of every active channel whose note matches. No match means no effect and no pulse. Tables are unchanged otherwise.
- EVENT always returns to IDLE after one cycle; note_ready is 0 in EVENT.
- SWEEP:
  - curr_note = 1 << chan, tuning_word = tuning[chan], chan_valid = 1.
  - chan increments each cycle. After chan = NUM_CHANNELS-1, go to IDLE.
  - note_ready = 0.
  - sample_tick seen in EVENT or SWEEP is dropped and sets overrun.
- acc_en mirrors the active bits. Inactive channels are still swept; their tuning register keeps its last value.

## Timing
- Every output is registered except note_ready, which is a combinational decode of state and sample_tick.
- Reset while rst is low:
  - state IDLE, all tables zero, steal_ptr 0.
  - acc_en, acc_clr, curr_note, tuning_word, chan_valid, voice_stolen, overrun all 0.
  - note_ready follows !sample_tick.
  - Reset mid-sweep or mid-event aborts immediately; the captured event is lost.
- Event accepted at edge t: EVENT during cycle t+1. acc_clr/voice_stolen pulse and the updated acc_en appear in cycle t+2, and state is IDLE in t+2. Peak throughput is one event per 2 cycles.
- sample_tick high in IDLE at edge t: channel k is presented in cycle t+1+k. chan_valid is high for exactly NUM_CHANNELS cycles. IDLE resumes in cycle t+1+NUM_CHANNELS.
- The minimum tick spacing without overrun is NUM_CHANNELS+1 cycles.
- acc_clr and curr_note never coincide on the same channel, because EVENT and SWEEP are mutually exclusive.

## Test plan
- Reset release, no stimulus -> all outputs 0, note_ready=1.
- note-on note 60 tw 0x0100_0000, then sample_tick -> acc_clr=0x0001 pulse in cycle t+2, acc_en=0x0001. Sweep gives curr_note 0x0001..0x8000 over 16 cycles, tuning_word=0x0100_0000 only on the first.
- 16 note-ons (notes 0..15), then note 99 tw 0x5 -> channel 0 overwritten, voice_stolen pulse, acc_clr=0x0001. A second extra note-on steals channel 1.
- note-on 60 twice with tw 0xA then 0xB -> same channel, tuning=0xB, voice_stolen stays 0. note-off 60 -> acc_en bit clears. note-off 61 (absent) -> no change.
- sample_tick and note_valid together in IDLE -> sweep starts, note_ready=0, event is accepted only after the sweep ends.
- sample_tick mid-sweep -> ignored, overrun=1 until reset. rst low mid-sweep -> curr_note=0 and state IDLE immediately.
